// File: rtl/fdiv.sv
// Multi-cycle IEEE-754 single-precision divider: restoring radix-2 quotient, round-to-nearest-even.
// Fixed 28-edge latency for every operand class; `FDIV_SPECIAL_EN enables NaN/Inf handling.
module fdiv (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        input_valid,
  output logic        input_ready,
  output logic [31:0] result,
  output logic        out_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_RND  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [25:0]       rem_q, rem_d;
  logic [23:0]       dvs_q, dvs_d;
  logic [25:0]       quo_q, quo_d;
  logic signed [9:0] exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              sp_q, sp_d;
  logic [31:0]       sp_res_q, sp_res_d;
  logic [31:0]       result_q, result_d;
  logic              out_valid_q, out_valid_d;

  // Operand unpack and prenormalisation
  logic [7:0]        ea, eb;
  logic [23:0]       ma, mb;
  logic              zero_a, zero_b, pre_shift, sign_in;
  logic signed [9:0] exp_in;
  logic [25:0]       rem_in;

  assign ea        = input_a[30:23];
  assign eb        = input_b[30:23];
  assign ma        = {1'b1, input_a[22:0]};
  assign mb        = {1'b1, input_b[22:0]};
  assign zero_a    = (ea == 8'd0);
  assign zero_b    = (eb == 8'd0);
  assign pre_shift = (ma < mb);
  assign sign_in   = input_a[31] ^ input_b[31];
  assign exp_in    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
                     - (pre_shift ? 10'sd1 : 10'sd0);
  assign rem_in    = pre_shift ? {1'b0, ma, 1'b0} : {2'b00, ma};

  logic        sp_hit;
  logic [31:0] sp_val;

`ifdef FDIV_SPECIAL_EN
  logic inf_a, inf_b, nan_a, nan_b;
  assign inf_a = (ea == 8'hFF) && (input_a[22:0] == 23'd0);
  assign inf_b = (eb == 8'hFF) && (input_b[22:0] == 23'd0);
  assign nan_a = (ea == 8'hFF) && (input_a[22:0] != 23'd0);
  assign nan_b = (eb == 8'hFF) && (input_b[22:0] != 23'd0);
`endif

  always_comb begin
    sp_hit = 1'b0;
    sp_val = 32'h0;
`ifdef FDIV_SPECIAL_EN
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      sp_hit = 1'b1;
      sp_val = 32'h7FC00000;
    end else if (inf_a) begin
      sp_hit = 1'b1;
      sp_val = {sign_in, 8'hFF, 23'd0};
    end else if (inf_b) begin
      sp_hit = 1'b1;
      sp_val = {sign_in, 31'd0};
    end else if (zero_a) begin
      sp_hit = 1'b1;
      sp_val = {sign_in, 31'd0};
    end else if (zero_b) begin
      sp_hit = 1'b1;
      sp_val = {sign_in, 8'hFF, 23'd0};
    end
`else
    if (zero_a) begin
      sp_hit = 1'b1;
      sp_val = {sign_in, 31'd0};
    end else if (zero_b) begin
      sp_hit = 1'b1;
      sp_val = {sign_in, 8'hFF, 23'd0};
    end
`endif
  end

  // Restoring step: quo_q[25] is the hidden bit, [1] guard, [0] round
  logic        step_ge;
  logic [25:0] step_diff;
  assign step_ge   = (rem_q >= {2'b00, dvs_q});
  assign step_diff = step_ge ? (rem_q - {2'b00, dvs_q}) : rem_q;

  logic              round_up;
  logic [23:0]       frac_sum;
  logic signed [9:0] exp_r;
  logic [31:0]       rnd_res;
  assign round_up = quo_q[1] & (quo_q[0] | (|rem_q) | quo_q[2]);
  assign frac_sum = {1'b0, quo_q[24:2]} + {23'd0, round_up};
  assign exp_r    = exp_q + $signed({9'd0, frac_sum[23]});

  always_comb begin
    if (exp_r <= 10'sd0)
      rnd_res = {sign_q, 31'd0};
    else if (exp_r >= 10'sd255)
      rnd_res = {sign_q, 8'hFF, 23'd0};
    else
      rnd_res = {sign_q, exp_r[7:0], (frac_sum[23] ? 23'd0 : frac_sum[22:0])};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    sp_d        = sp_q;
    sp_res_d    = sp_res_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (input_valid) begin
          state_d  = S_DIV;
          cnt_d    = 5'd26;
          rem_d    = rem_in;
          dvs_d    = mb;
          quo_d    = 26'd0;
          exp_d    = exp_in;
          sign_d   = sign_in;
          sp_d     = sp_hit;
          sp_res_d = sp_val;
        end
      end
      S_DIV: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
          quo_d = {quo_q[24:0], step_ge};
          rem_d = {step_diff[24:0], 1'b0};
        end else begin
          state_d = S_RND;
        end
      end
      S_RND: begin
        result_d    = sp_q ? sp_res_q : rnd_res;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      rem_q       <= 26'd0;
      dvs_q       <= 24'd0;
      quo_q       <= 26'd0;
      exp_q       <= 10'sd0;
      sign_q      <= 1'b0;
      sp_q        <= 1'b0;
      sp_res_q    <= 32'd0;
      result_q    <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      sp_q        <= sp_d;
      sp_res_q    <= sp_res_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign input_ready = (state_q == S_IDLE);
  assign result      = result_q;
  assign out_valid   = out_valid_q;

endmodule

// File: doc/fdiv.md
FDIV -- requirements
Module: fdiv

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port `input_a`, input, 32 bits: IEEE-754 single-precision dividend.
REQ-005 Port `input_b`, input, 32 bits: IEEE-754 single-precision divisor.
REQ-006 Port `input_valid`, input, 1 bit: operands present this cycle.
REQ-007 Port `input_ready`, output, 1 bit: block can accept operands (high only in IDLE).
REQ-008 Port `result`, output, 32 bits: quotient; holds its last value between completions.
REQ-009 Port `out_valid`, output, 1 bit: one-cycle pulse marking a new `result`.

Function
REQ-010 Operands SHALL be accepted on a rising edge where `input_valid` and `input_ready` are both 1; `input_valid` in any other state SHALL be ignored.
REQ-011 The FSM SHALL have three states with these transitions:
- IDLE -> DIV on accept.
- DIV -> RND after 26 iteration cycles (5-bit down-counter).
- RND -> IDLE after 1 cycle.
REQ-012 Latency SHALL be fixed for every operand class, including special cases: `out_valid` is high exactly in the cycle after the 28th rising edge following the accepting edge.
REQ-013 On the RND->IDLE edge the block SHALL register `result` and pulse `out_valid` for one cycle; the block SHALL NOT accept new operands on that edge.
REQ-014 Unpacking on load:
- Operand `input_a` gives exponent ea and significand ma = {1, frac}.
- Operand `input_b` gives exponent eb and significand mb = {1, frac}.
- Sign = sign_a XOR sign_b.
- Exponent e = ea - eb + 127, computed in 10-bit signed arithmetic.
REQ-015 Prenormalize: if ma < mb, the dividend SHALL be shifted left 1 bit and e decremented by 1, so the quotient lies in [1,2).
REQ-016 DIV SHALL run restoring radix-2 division, producing one quotient bit per cycle, 26 bits in total (hidden bit, 23 fraction bits, guard, round).
REQ-017 sticky SHALL be the OR of all final remainder bits.
REQ-018 Rounding SHALL be round-to-nearest-even: round up = guard AND (round OR sticky OR lsb).
REQ-019 If rounding carries out of the 23-bit fraction, the fraction SHALL become 0 and e SHALL be incremented.
REQ-020 After rounding, e <= 0 SHALL produce signed zero (no subnormal output).
REQ-021 After rounding, e >= 255 SHALL produce signed infinity: {sign, 8'hFF, 23'b0}.
REQ-022 An operand with exponent field 0 (zero or subnormal) SHALL be treated as zero.
REQ-023 Zero-operand results, with dividend-zero taking priority:
- Dividend zero gives {sign, 31'b0}.
- Otherwise divisor zero gives {sign, 8'hFF, 23'b0}.
REQ-024 Special cases SHALL still traverse DIV and RND so that latency stays per REQ-012.

Reset
REQ-025 While `rst` is 1, the block SHALL hold:
- FSM = IDLE, `input_ready` = 1.
- `out_valid` = 0, `result` = 32'h0.
- Counter and datapath registers = 0.
REQ-026 Reset asserted mid-operation SHALL abort the operation: no `out_valid` pulse, and `result` = 0.
REQ-027 The first accept SHALL be possible on the first rising edge after `rst` deasserts.

Configuration
REQ-028 Macro `FDIV_SPECIAL_EN` selects special-value handling.
REQ-029 When `FDIV_SPECIAL_EN` is defined, these results SHALL take priority over REQ-023:
- Any NaN operand gives 32'h7FC00000.
- 0/0 and Inf/Inf give 32'h7FC00000.
- Inf/finite gives signed Inf.
- finite/Inf gives signed zero.
REQ-030 When `FDIV_SPECIAL_EN` is undefined:
- Exponent 255 SHALL be treated as an ordinary exponent.
- 0/0 SHALL give signed zero per REQ-023.
- No NaN SHALL ever be generated.

Verification
REQ-031 Exact quotient and latency: 32'h40C00000 / 32'h40000000 accepted at edge E0 -> `result` = 32'h40400000, `out_valid` high only after edge E0+28; `input_ready` = 0 during edges E0+1 through E0+28.
REQ-032 Rounding: 32'h3F800000 / 32'h40400000 -> 32'h3EAAAAAB; 32'hBF800000 / 32'h40400000 -> 32'hBEAAAAAB.
REQ-033 Zero operands: 32'h3F800000 / 32'h00000000 -> 32'h7F800000; 32'hBF800000 / 32'h00000000 -> 32'hFF800000; 32'h00000000 / 32'h40A00000 -> 32'h00000000.
REQ-034 Range limits: 32'h7F000000 / 32'h3E800000 -> 32'h7F800000 (overflow); 32'h00800000 / 32'h40000000 -> 32'h00000000 (underflow flush).
REQ-035 Handshake and reset: pulse `input_valid` during DIV -> ignored, one `out_valid` only; assert `rst` 10 cycles after an accept -> no `out_valid`, `result` = 0, `input_ready` = 1 next cycle.
REQ-036 Macro on/off: with `FDIV_SPECIAL_EN`, 0/0, 32'h7F800000/32'h7F800000 and 32'h7FC00001/32'h3F800000 -> 32'h7FC00000; without it, 0/0 -> 32'h00000000.
